// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding,
// default geometry and the address classification helpers used to decide
// whether a request may touch the RAM.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;
    localparam int unsigned DMEM_IDX_W         = $clog2(DMEM_DEPTH_DEFAULT);

    // True when addr is word-aligned and falls inside [base, base + 4*depth).
    // The range test is done on the offset in 33 bits so a window ending at
    // the top of the address space cannot wrap.
    function automatic logic addr_ok(input logic [31:0]  addr,
                                     input logic [31:0]  base,
                                     input int unsigned  depth);
        logic [32:0] off;
        logic [32:0] lim;
        off = {1'b0, addr} - {1'b0, base};
        lim = 33'(depth) << 2;
        return (addr[1:0] == 2'b00) && (addr >= base) && (off < lim);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side bus of the data-memory controller.
//   master (core):       drives MemRead, MemWrite, dAddress, dWriteData
//   slave  (controller): drives dReadData, ready, err, err_count
interface data_mem_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        ready;
    logic        err;
    logic [7:0]  err_count;

    modport master (
        output MemRead, MemWrite, dAddress, dWriteData,
        input  dReadData, ready, err, err_count
    );

    modport slave (
        input  MemRead, MemWrite, dAddress, dWriteData,
        output dReadData, ready, err, err_count
    );
endinterface

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port synchronous word RAM with registered read data.
//   clk   : clock, rising edge
//   en    : access enable for this edge
//   we    : 1 = write wdata to idx, 0 = read idx into rdata
//   idx   : word index
//   wdata : write data
//   rdata : read data, updated only on enabled reads
// Contents and rdata are deliberately not reset so the array maps onto
// block RAM; the controller masks rdata until the first valid read.
module dmem_array #(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the core's MEM stage.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of data_mem_ctrl_if
//         MemRead/MemWrite/dAddress/dWriteData in,
//         dReadData (held load data), ready/err (one-cycle pulses),
//         err_count (saturating errored-request count) out
// Requests are accepted in IDLE, optionally delayed WAIT_STATES edges in
// BUSY, and acknowledged for one cycle in RESP.
//
// state | meaning
// IDLE  | waiting for MemRead|MemWrite
// BUSY  | request latched, counting down wait states
// RESP  | ready (and err if bad) high for this cycle
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic           clk,
    input logic           rst,
    data_mem_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t      state;
    logic [3:0]       cnt;
    logic             lat_rd;
    logic             lat_wr;
    logic             lat_ok;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_wdata;
    logic             rd_zero;
    logic             ready_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;

    logic             req_any;
    logic             req_ok;
    logic [IDX_W-1:0] req_idx;

    logic             acc_fire;
    logic             acc_rd;
    logic             acc_wr;
    logic             acc_ok;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;

    logic             ram_en;
    logic [31:0]      ram_rdata;

    assign req_any = bus.MemRead | bus.MemWrite;
    assign req_ok  = addr_ok(bus.dAddress, BASE_ADDR, DEPTH_WORDS) &&
                     !(bus.MemRead && bus.MemWrite);
    assign req_idx = IDX_W'((bus.dAddress - BASE_ADDR) >> 2);

    // With no wait states the access happens on the acceptance edge, so it
    // is fed straight from the bus; otherwise it uses the latched request.
    always_comb begin
        acc_fire  = 1'b0;
        acc_rd    = lat_rd;
        acc_wr    = lat_wr;
        acc_ok    = lat_ok;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        if (state == IDLE && req_any && WAIT_STATES == 0) begin
            acc_fire  = 1'b1;
            acc_rd    = bus.MemRead;
            acc_wr    = bus.MemWrite;
            acc_ok    = req_ok;
            acc_idx   = req_idx;
            acc_wdata = bus.dWriteData;
        end else if (state == BUSY && cnt == 4'd1) begin
            acc_fire = 1'b1;
        end
    end

    // Gate with rst so an edge seen while reset is held can never write.
    assign ram_en = acc_fire && acc_ok && !rst;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_wr),
        .idx  (acc_idx),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_ok    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            rd_zero   <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        lat_rd    <= bus.MemRead;
                        lat_wr    <= bus.MemWrite;
                        lat_ok    <= req_ok;
                        lat_idx   <= req_idx;
                        lat_wdata <= bus.dWriteData;
                        if (WAIT_STATES != 0) begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_STATES);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (acc_fire) begin
                state   <= RESP;
                ready_q <= 1'b1;
                err_q   <= !acc_ok;
                if (!acc_ok && err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
                // Good reads expose the RAM output; a bad single read forces
                // zero. Writes and dual-op requests leave the load data alone.
                if (acc_ok && acc_rd) begin
                    rd_zero <= 1'b0;
                end else if (!acc_ok && acc_rd && !acc_wr) begin
                    rd_zero <= 1'b1;
                end
            end
        end
    end

    assign bus.dReadData = rd_zero ? 32'd0 : ram_rdata;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller directly downstream of the multicycle core's MEM stage. It consumes MemRead/MemWrite, dAddress and dWriteData, and produces dReadData for the core's write-back path. It owns a word-addressed data RAM, applies a configurable number of wait states, and flags misaligned, out-of-range and conflicting accesses. Errors are reported through a one-cycle status pulse and a saturating error counter.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data RAM (power of two)
BASE_ADDR, 32'h10010000, byte address of word 0; must be word-aligned
WAIT_STATES, 0, extra cycles between request acceptance and access; 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
MemRead  input  1  read request level from core
MemWrite  input  1  write request level from core
dAddress  input  32  byte address of access
dWriteData  input  32  store data
dReadData  output  32  registered load data
ready  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with ready
err_count  output  8  saturating count of errored requests

Behaviour:
- Reset (async, rst=1): state=IDLE, dReadData=0, ready=0, err=0, err_count=0, wait counter=0. RAM contents are not cleared.
- Reset mid-operation: pending request aborted; a write not yet performed is never performed.
- States: IDLE, BUSY, RESP.
- IDLE: at a rising edge with MemRead|MemWrite=1, the request is accepted. Address, data and op are latched and classified:
  - ok: dAddress[1:0]==0 and BASE_ADDR <= dAddress < BASE_ADDR+4*DEPTH_WORDS (32-bit unsigned compare).
  - bad: misaligned, out of range, or MemRead&MemWrite both 1.
  - Word index = (dAddress-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
- Timing:
  - WAIT_STATES=0: the access happens at the acceptance edge; next state RESP.
  - WAIT_STATES>0: next state BUSY with counter=WAIT_STATES. Each BUSY edge decrements the counter. The access happens at the edge where counter==1, then RESP.
  - Latency: acceptance edge to access edge = WAIT_STATES edges. ready is high during the cycle that follows the access edge.
- Access:
  - ok write: RAM[index]<=latched data; dReadData unchanged.
  - ok read: dReadData<=RAM[index].
  - bad read (single op): no RAM access, dReadData<=0.
  - bad write or both high: no RAM write, dReadData unchanged.
- RESP: ready=1 for exactly one cycle. err=1 that cycle if the request was bad, and err_count increments, saturating at 8'hFF. Unconditional return to IDLE. Requests present during RESP are ignored.
- BUSY: input changes are ignored; latched values are used.
- dReadData holds its value until the next read access or reset. This keeps the core's WB-cycle capture stable.
- Back-to-back requests: the minimum spacing between acceptances is WAIT_STATES+2 cycles. The core's 5-state cycle satisfies this for WAIT_STATES<=3.
- ready and err are registered outputs (no combinational paths from inputs).

Decomposition:
- Shared package (data_mem_pkg): state encodings IDLE/BUSY/RESP, address-classification function (aligned and range check against BASE_ADDR/DEPTH_WORDS), index width constant $clog2(DEPTH_WORDS).
- One sub-module, dmem_array: single-port synchronous RAM with write enable, word index, write data and registered read data. data_mem_ctrl handles the FSM, counter, classification, error logic and output register muxing.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10010004 (MemWrite one cycle), then read 0x10010004 -> dReadData=0xDEADBEEF and ready=1 in the cycle after the read edge; err=0; ready is a one-cycle pulse.
- WAIT_STATES=2: MemRead to 0x10010004 accepted at E0; toggle MemRead and change dAddress to 0x10010008 at E1 -> dReadData changes only after E2 to 0xDEADBEEF; ready high only in the cycle after E2.
- Misaligned write of 0x12345678 to 0x10010006 -> ready=1, err=1, err_count=1; a later read of 0x10010004 still returns 0xDEADBEEF.
- Out-of-range read of 0x10011000 (DEPTH=1024) -> dReadData=0, err=1, err_count increments; read of 0x1000FFFC also errors.
- MemRead=MemWrite=1 at 0x10010004 with data 0x0 -> err=1, no write; a subsequent read returns 0xDEADBEEF. Repeat 300 errored requests -> err_count saturates at 0xFF.
- WAIT_STATES=3: write 0xCAFEF00D to 0x10010004, assert rst during BUSY (between clock edges) -> outputs zero immediately, err_count=0, no ready pulse; after release, read 0x10010004 returns 0xDEADBEEF.
